// File: rtl/cfg_ff_slice.sv
// Serially configured slice of N flops. Each flop has a programmable enable
// polarity and an optional sync/async reset with selectable polarity and value.
module cfg_ff_slice #(
   parameter int N  = 4,
   parameter int CW = 6   // per-flop field layout below assumes exactly 6 bits
) (
   input  logic         clk,
   input  logic         nreset,
   input  logic         cfg_en,
   input  logic         cfg_in,
   output logic         cfg_out,
   output logic         cfg_done,
   input  logic [N-1:0] d,
   input  logic [N-1:0] e,
   input  logic [N-1:0] r,
   output logic [N-1:0] q
);
   localparam int NB   = N * CW;
   localparam int CNTW = $clog2(NB + 1);
   localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NB - 1);

   typedef enum logic [1:0] {UNCFG, LOAD, RUN} state_t;

   state_t          state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [NB-1:0]   cfg_q, cfg_d;
   logic            in_run, enter_run, user_edge;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cfg_d   = cfg_q;
      case (state_q)
         UNCFG, RUN: begin
            if (cfg_en) begin
               cfg_d   = {cfg_in, cfg_q[NB-1:1]};
               cnt_d   = CNT_ONE;
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (cfg_en) begin
               cfg_d = {cfg_in, cfg_q[NB-1:1]};
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_q == CNT_LAST) begin
                  state_d = RUN;
               end
            end
         end
         default: begin
            state_d = UNCFG;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= UNCFG;
         cnt_q   <= '0;
         cfg_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cfg_q   <= cfg_d;
      end
   end

   assign in_run    = (state_q == RUN);
   assign enter_run = (state_q == LOAD) && (state_d == RUN);
   // A reconfiguration request in RUN freezes user data on that edge.
   assign user_edge = in_run & ~cfg_en;
   assign cfg_out   = cfg_q[0];
   assign cfg_done  = in_run;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_flop
         logic en_used, en_inv, rst_used, rst_sync, rst_hi, rst_val;
         logic ract, en_act, arst, flop_d, flop_q;

         assign en_used  = cfg_q[gi*CW + 0];
         assign en_inv   = cfg_q[gi*CW + 1];
         assign rst_used = cfg_q[gi*CW + 2];
         assign rst_sync = cfg_q[gi*CW + 3];
         assign rst_hi   = cfg_q[gi*CW + 4];
         assign rst_val  = cfg_q[gi*CW + 5];

         assign ract   = rst_used & (rst_hi ? r[gi] : ~r[gi]);
         assign en_act = ~en_used | (e[gi] ^ en_inv);
         // Only a running slice may let r reach the asynchronous path.
         assign arst   = in_run & ~rst_sync & ract;

         always_comb begin
            flop_d = flop_q;
            if (enter_run) begin
               flop_d = cfg_d[gi*CW + 5];
            end else if (user_edge) begin
               if (ract) begin
                  flop_d = rst_val;
               end else if (en_act) begin
                  flop_d = d[gi];
               end
            end
         end

         always_ff @(posedge clk or negedge nreset or posedge arst) begin
            if (!nreset) begin
               flop_q <= 1'b0;
            end else if (arst) begin
               flop_q <= rst_val;
            end else begin
               flop_q <= flop_d;
            end
         end

         assign q[gi] = flop_q;
      end
   endgenerate
endmodule

// File: tb/tb_cfg_ff_slice.sv
// Two chained cfg_ff_slice instances (N=2) checked against a queue-history
// reference model through an expectation scoreboard.
module tb_cfg_ff_slice;
   localparam int N  = 2;
   localparam int CW = 6;
   localparam int NB = N * CW;
   localparam int S_UNCFG = 0;
   localparam int S_LOAD  = 1;
   localparam int S_RUN   = 2;

   logic         clk = 1'b0;
   logic         nreset = 1'b0;
   logic         cfg_en = 1'b0;
   logic         cfg_in = 1'b0;
   logic [N-1:0] d = '0;
   logic [N-1:0] e = '0;
   logic [N-1:0] r = '0;
   logic         out_a, out_b, done_a, done_b;
   logic [N-1:0] q_a, q_b;

   cfg_ff_slice #(.N(N)) u_a (
      .clk(clk), .nreset(nreset), .cfg_en(cfg_en), .cfg_in(cfg_in),
      .cfg_out(out_a), .cfg_done(done_a), .d(d), .e(e), .r(r), .q(q_a)
   );
   cfg_ff_slice #(.N(N)) u_b (
      .clk(clk), .nreset(nreset), .cfg_en(cfg_en), .cfg_in(out_a),
      .cfg_out(out_b), .cfg_done(done_b), .d(d), .e(e), .r(r), .q(q_b)
   );

   always #5 clk = ~clk;

   int cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   // Reference model: each slice keeps the history of bits it has shifted in;
   // config bit j is the bit shifted NB-j shifts ago (0 if never filled).
   bit           hist_a[$];
   bit           hist_b[$];
   int           m_st[2];
   int           m_cnt[2];
   logic [N-1:0] m_q[2];

   function automatic bit cfg_bit(int s, int j);
      int idx;
      if (s == 0) begin
         idx = hist_a.size() - NB + j;
         if (idx < 0) return 1'b0;
         return hist_a[idx];
      end
      idx = hist_b.size() - NB + j;
      if (idx < 0) return 1'b0;
      return hist_b[idx];
   endfunction

   function automatic bit fld(int s, int i, int b);
      return cfg_bit(s, i*CW + b);
   endfunction

   function automatic bit ract(int s, int i, logic [N-1:0] rv);
      return fld(s, i, 2) && (fld(s, i, 4) ? rv[i] : !rv[i]);
   endfunction

   function automatic bit enact(int s, int i, logic [N-1:0] ev);
      return !fld(s, i, 0) || (ev[i] != fld(s, i, 1));
   endfunction

   function automatic void model_reset();
      hist_a.delete();
      hist_b.delete();
      for (int s = 0; s < 2; s++) begin
         m_st[s]  = S_UNCFG;
         m_cnt[s] = 0;
         m_q[s]   = '0;
      end
   endfunction

   function automatic void model_async(logic [N-1:0] rv);
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < N; i++)
            if (m_st[s] == S_RUN && !fld(s, i, 3) && ract(s, i, rv))
               m_q[s][i] = fld(s, i, 5);
   endfunction

   function automatic void model_edge(bit en, bit bin, logic [N-1:0] dv,
                                      logic [N-1:0] ev, logic [N-1:0] rv);
      bit chain;
      chain = cfg_bit(0, 0);
      for (int s = 0; s < 2; s++) begin
         if (m_st[s] == S_RUN && !en) begin
            for (int i = 0; i < N; i++) begin
               if (ract(s, i, rv)) m_q[s][i] = fld(s, i, 5);
               else if (enact(s, i, ev)) m_q[s][i] = dv[i];
            end
         end
         if (en) begin
            if (s == 0) hist_a.push_back(bin);
            else        hist_b.push_back(chain);
            if (m_st[s] == S_LOAD) m_cnt[s]++;
            else                   m_cnt[s] = 1;
            m_st[s] = S_LOAD;
            if (m_cnt[s] == NB) begin
               m_st[s] = S_RUN;
               for (int i = 0; i < N; i++) m_q[s][i] = fld(s, i, 5);
            end
         end
      end
   endfunction

   function automatic logic [7:0] model_vec();
      return {m_q[0], m_q[1], m_st[0] == S_RUN, m_st[1] == S_RUN,
              cfg_bit(0, 0), cfg_bit(1, 0)};
   endfunction

   typedef struct {
      int         cyc;
      logic [7:0] exp;
      string      tag;
   } exp_t;

   exp_t sb[$];
   exp_t asb[$];
   event async_ev;
   int   checks = 0;
   int   failures = 0;

   task automatic compare(input exp_t x);
      logic [7:0] act;
      act = {q_a, q_b, done_a, done_b, out_a, out_b};
      checks++;
      if (act !== x.exp) begin
         failures++;
         $display("FAIL %-12s t=%0t {qa,qb,done_a,done_b,out_a,out_b} got=%b want=%b",
                  x.tag, $time, act, x.exp);
      end else begin
         $display("ok   %-12s t=%0t state=%b", x.tag, $time, act);
      end
   endtask

   // Edge monitor: compares every expectation due at this cycle.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cycle) compare(sb.pop_front());
   end

   // Asynchronous monitor: compares mid-cycle expectations.
   initial begin
      forever begin
         @(async_ev);
         while (asb.size() > 0) compare(asb.pop_front());
      end
   end

   function automatic logic [N-1:0] rnd();
      return N'($urandom_range(0, (1 << N) - 1));
   endfunction

   task automatic step(input bit en, input bit bin, input logic [N-1:0] dv,
                       input logic [N-1:0] ev, input logic [N-1:0] rv,
                       input string tag, input bit achk);
      @(negedge clk);
      #1;
      cfg_en = en;
      cfg_in = bin;
      d = dv;
      e = ev;
      r = rv;
      model_async(rv);
      if (achk) begin
         #2;
         asb.push_back('{cyc: cycle, exp: model_vec(), tag: {tag, "_async"}});
         ->async_ev;
      end
      model_edge(en, bin, dv, ev, rv);
      model_async(rv);
      sb.push_back('{cyc: cycle + 1, exp: model_vec(), tag: tag});
   endtask

   task automatic pulse_reset(input string tag);
      @(negedge clk);
      #1;
      nreset = 1'b0;
      cfg_en = 1'b0;
      model_reset();
      #2;
      asb.push_back('{cyc: cycle, exp: model_vec(), tag: tag});
      ->async_ev;
      @(negedge clk);
      #1;
      nreset = 1'b1;
   endtask

   logic [NB-1:0] pat;

   initial begin
      model_reset();
      #3;
      asb.push_back('{cyc: cycle, exp: model_vec(), tag: "reset"});
      ->async_ev;
      @(negedge clk);
      #1;
      nreset = 1'b1;

      step(1'b0, 1'b0, rnd(), rnd(), rnd(), "idle_uncfg", 1'b0);
      for (int j = 0; j < NB; j++) step(1'b1, 1'b0, rnd(), rnd(), rnd(), "load_plain", 1'b0);
      step(1'b0, 1'b0, 2'b10, rnd(), rnd(), "plain_d10", 1'b0);
      repeat (6) step(1'b0, 1'b0, rnd(), rnd(), rnd(), "plain_rand", 1'b0);

      // flop0: sync active-low reset to 1 with enable; flop1: async active-high reset to 0
      pat = {6'b010100, 6'b101101};
      for (int j = 0; j < 7; j++) step(1'b1, pat[j], rnd(), rnd(), rnd(), "cfg_shift", 1'b0);
      repeat (5) step(1'b0, 1'b0, rnd(), rnd(), rnd(), "cfg_pause", 1'b0);
      for (int j = 7; j < NB; j++) step(1'b1, pat[j], rnd(), rnd(), rnd(), "cfg_shift", 1'b0);

      step(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, "sync_rst", 1'b0);
      step(1'b0, 1'b0, 2'b00, 2'b01, 2'b01, "en_d0", 1'b0);
      step(1'b0, 1'b0, 2'b00, 2'b01, 2'b00, "rst_beats_en", 1'b0);
      step(1'b0, 1'b0, 2'b10, 2'b00, 2'b01, "q1_set", 1'b0);
      step(1'b0, 1'b0, 2'b10, 2'b00, 2'b11, "async_r1", 1'b1);
      step(1'b0, 1'b0, 2'b10, 2'b00, 2'b01, "q1_resume", 1'b0);

      step(1'b1, 1'($urandom_range(0, 1)), ~q_a, 2'b11, 2'b01, "cfg_vs_data", 1'b0);
      for (int j = 1; j < 9; j++)
         step(1'b1, 1'($urandom_range(0, 1)), rnd(), rnd(), rnd(), "reload", 1'b0);
      pulse_reset("reset_mid_load");
      for (int j = 0; j < NB; j++)
         step(1'b1, 1'($urandom_range(0, 1)), rnd(), rnd(), rnd(), "full_reload", 1'b0);

      pulse_reset("reset_chain");
      repeat (5) begin
         for (int j = 0; j < 2*NB; j++)
            step(1'b1, 1'($urandom_range(0, 1)), rnd(), rnd(), rnd(), "chain_shift", 1'b0);
         repeat (16)
            step(1'b0, 1'b0, rnd(), rnd(), rnd(), "run_rand", 1'($urandom_range(0, 3) == 0));
         step(1'b1, 1'($urandom_range(0, 1)), rnd(), rnd(), rnd(), "cfg_vs_data", 1'b0);
      end

      repeat (3) @(negedge clk);
      if (sb.size() != 0 || asb.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", sb.size() + asb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL timeout t=%0t required=finished", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
